seg_scan_driver: RTL and testbench

Parametrised multiplexed driver for a bank of common-anode 7-segment digits.
- Takes packed hex nibbles plus per-digit decimal-point and blank masks.
- Double-buffers them so frames never tear, and time-multiplexes the digits by cycling active-low anode selects.
- Sits between game/score logic and the board's segment/anode pins, replacing per-digit static decoders.

---
 rtl/seg_scan_driver.sv | 178 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver with double-buffered frame data.
// Optional leading-zero suppression is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver #(
  parameter int DIGITS      = 8,
  parameter int SCAN_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp,
  input  logic [DIGITS-1:0]   blank,
  output logic [7:0]          seg_n,
  output logic [DIGITS-1:0]   an_n,
  output logic                frame_start
);

  localparam int PW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(SCAN_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]       psc_q, psc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                run_q, run_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic                pend_valid_q, pend_valid_d;
  logic [7:0]          seg_n_q, seg_n_d;
  logic [DIGITS-1:0]   an_n_q, an_n_d;
  logic                frame_start_q, frame_start_d;

  logic       tick, wrap;
  logic [3:0] cur_nib;
  logic       cur_dp, cur_blank, cur_supp;
  logic [7:0] cur_code;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic       higher_zero;
  logic       nib_zero;
`endif

  function automatic logic [7:0] hex_code(input logic [3:0] n);
    case (n)
      4'h0: hex_code = 8'hC0;
      4'h1: hex_code = 8'hF9;
      4'h2: hex_code = 8'hA4;
      4'h3: hex_code = 8'hB0;
      4'h4: hex_code = 8'h99;
      4'h5: hex_code = 8'h92;
      4'h6: hex_code = 8'h82;
      4'h7: hex_code = 8'hF8;
      4'h8: hex_code = 8'h80;
      4'h9: hex_code = 8'h90;
      4'hA: hex_code = 8'h88;
      4'hB: hex_code = 8'h83;
      4'hC: hex_code = 8'hC6;
      4'hD: hex_code = 8'hA1;
      4'hE: hex_code = 8'h86;
      4'hF: hex_code = 8'h8E;
    endcase
  endfunction

  always_comb begin
    psc_d         = psc_q;
    idx_d         = idx_q;
    run_d         = en;
    pend_data_d   = pend_data_q;
    pend_dp_d     = pend_dp_q;
    pend_blank_d  = pend_blank_q;
    pend_valid_d  = pend_valid_q;
    act_data_d    = act_data_q;
    act_dp_d      = act_dp_q;
    act_blank_d   = act_blank_q;
    cur_nib       = 4'h0;
    cur_dp        = 1'b0;
    cur_blank     = 1'b1;
    cur_supp      = 1'b0;
    cur_code      = 8'hFF;
    seg_n_d       = 8'hFF;
    an_n_d        = '1;

    tick          = run_q && (psc_q == PSC_LAST);
    wrap          = en && tick && (idx_q == IDX_LAST);
    frame_start_d = wrap;

    // The first enabled cycle after reset or en low restarts digit 0 with a full slot.
    if (!en || !run_q) begin
      psc_d = '0;
      idx_d = '0;
    end else if (tick) begin
      psc_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      psc_d = psc_q + 1'b1;
    end

    if (wrap && load) begin
      act_data_d   = data;
      act_dp_d     = dp;
      act_blank_d  = blank;
      pend_valid_d = 1'b0;
    end else if (wrap && pend_valid_q) begin
      act_data_d   = pend_data_q;
      act_dp_d     = pend_dp_q;
      act_blank_d  = pend_blank_q;
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_data_d  = data;
      pend_dp_d    = dp;
      pend_blank_d = blank;
      pend_valid_d = 1'b1;
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    higher_zero = 1'b1;
    nib_zero    = 1'b0;
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
      nib_zero = (act_data_d[4*i +: 4] == 4'h0);
      if (IW'(i) == idx_d) cur_supp = (i != 0) && nib_zero && higher_zero;
      higher_zero = higher_zero && (nib_zero || act_blank_d[i]);
`endif
      if (IW'(i) == idx_d) begin
        cur_nib   = act_data_d[4*i +: 4];
        cur_dp    = act_dp_d[i];
        cur_blank = act_blank_d[i];
      end
    end

    cur_code = hex_code(cur_nib);
    if (en) begin
      an_n_d = ~(DIGITS'(1) << idx_d);
      if (cur_blank)     seg_n_d = 8'hFF;
      else if (cur_supp) seg_n_d = {~cur_dp, 7'h7F};
      else               seg_n_d = {~cur_dp, cur_code[6:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q         <= '0;
      idx_q         <= '0;
      run_q         <= 1'b0;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '1;
      pend_valid_q  <= 1'b0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
      seg_n_q       <= 8'hFF;
      an_n_q        <= '1;
      frame_start_q <= 1'b0;
    end else begin
      psc_q         <= psc_d;
      idx_q         <= idx_d;
      run_q         <= run_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_valid_q  <= pend_valid_d;
      act_data_q    <= act_data_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      seg_n_q       <= seg_n_d;
      an_n_q        <= an_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg_n       = seg_n_q;
  assign an_n        = an_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (DIGITS=4, SCAN_CYCLES=4) against a frame-level model.
module tb_seg_scan_driver;

  localparam int DIGITS = 4;
  localparam int SCAN   = 4;
  localparam int FRAME  = DIGITS * SCAN;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '1;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_start;

  seg_scan_driver #(.DIGITS(DIGITS), .SCAN_CYCLES(SCAN)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data(data), .dp(dp),
    .blank(blank), .seg_n(seg_n), .an_n(an_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   armed = 1'b0;
  logic prev_rst = 1'b0;

  // Model: display cycles counted since enable; frame boundaries every FRAME cycles.
  int          disp_cnt;
  logic [15:0] m_pdata, m_adata;
  logic [3:0]  m_pdp, m_adp, m_pblank, m_ablank;
  bit          m_pvalid;
  logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %h want %h", name, $time, act, want);
    end
  endtask

  function automatic logic [7:0] model_seg(input int d);
    logic [3:0] nib;
    logic [7:0] code;
    nib = m_adata[4*d +: 4];
    code = hex_tab[nib];
    if (m_ablank[d]) return 8'hFF;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (d >= 1 && nib == 4'h0) begin
      bit lead = 1'b1;
      for (int j = d + 1; j < DIGITS; j++)
        if (!(m_adata[4*j +: 4] == 4'h0 || m_ablank[j])) lead = 1'b0;
      if (lead) return {~m_adp[d], 7'h7F};
    end
`endif
    return {~m_adp[d], code[6:0]};
  endfunction

  task automatic model_reset();
    disp_cnt = -1;
    m_pdata = '0; m_pdp = '0; m_pblank = '1; m_pvalid = 1'b0;
    m_adata = '0; m_adp = '0; m_ablank = '1;
  endtask

  task automatic apply_stimulus(input logic r, input logic e, input logic l,
                                input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    exp_t x;
    bit   boundary;
    int   digit;
    @(negedge clk);
    rst_n = r; en = e; load = l; data = d; dp = p; blank = b;
    boundary = 1'b0;
    if (!r) begin
      model_reset();
      x = '{seg: 8'hFF, an: 4'hF, fs: 1'b0};
    end else if (!e) begin
      disp_cnt = -1;
      if (l) begin m_pdata = d; m_pdp = p; m_pblank = b; m_pvalid = 1'b1; end
      x = '{seg: 8'hFF, an: 4'hF, fs: 1'b0};
    end else begin
      if (disp_cnt < 0) disp_cnt = 0;
      else begin
        disp_cnt++;
        boundary = (disp_cnt % FRAME) == 0;
      end
      if (boundary) begin
        if (l) begin m_adata = d; m_adp = p; m_ablank = b; end
        else if (m_pvalid) begin m_adata = m_pdata; m_adp = m_pdp; m_ablank = m_pblank; end
        m_pvalid = 1'b0;
      end else if (l) begin
        m_pdata = d; m_pdp = p; m_pblank = b; m_pvalid = 1'b1;
      end
      digit = (disp_cnt / SCAN) % DIGITS;
      x.an  = ~(4'(1) << digit);
      x.seg = model_seg(digit);
      x.fs  = boundary;
    end
    exp_q.push_back(x);
    armed = 1'b1;
    if (!r && prev_rst) begin
      #1;
      check_output("async_rst_seg", seg_n, 8'hFF);
      check_output("async_rst_an", {4'h0, an_n}, 8'h0F);
      check_output("async_rst_fs", {7'h0, frame_start}, 8'h00);
    end
    prev_rst = r;
  endtask

  task automatic run(input int n, input logic e);
    repeat (n) apply_stimulus(1'b1, e, 1'b0, data, dp, blank);
  endtask

  task automatic load_now(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    apply_stimulus(1'b1, 1'b1, 1'b1, d, p, b);
  endtask

  task automatic run_to_wrap();
    int guard = 0;
    while (!(disp_cnt >= 0 && ((disp_cnt + 1) % FRAME) == 0) && guard < FRAME + 2) begin
      run(1, 1'b1);
      guard++;
    end
  endtask

  // Monitor: one expected entry per clock edge, compared shortly after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (armed) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL queue_underflow at %0t: got empty want entry", $time);
        end else begin
          x = exp_q.pop_front();
          check_output("an_n", {4'h0, an_n}, {4'h0, x.an});
          check_output("seg_n", seg_n, x.seg);
          check_output("frame_start", {7'h0, frame_start}, {7'h0, x.fs});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL timeout at %0t: got running want finished", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    model_reset();
    repeat (3) apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 4'hF);
    run(20, 1'b1);

    run(6, 1'b1);
    load_now(16'h1A3F, 4'b0010, 4'b0000);
    run(30, 1'b1);

    run_to_wrap();
    load_now(16'h5B07, 4'b0001, 4'b0000);
    run(5, 1'b1);
    load_now(16'hAAAA, 4'b1111, 4'b0000);
    run(3, 1'b1);
    load_now(16'hC0DE, 4'b0100, 4'b0000);
    run(30, 1'b1);

    run(5, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b1, 16'h2468, 4'b0000, 4'b0000);
    run(3, 1'b0);
    run(36, 1'b1);

    load_now(16'h8888, 4'b0000, 4'b0100);
    run(40, 1'b1);

    load_now(16'h0050, 4'b1000, 4'b0000);
    run(40, 1'b1);

    load_now(16'h0000, 4'b0000, 4'b0000);
    run(34, 1'b1);

    for (int k = 0; k < 400; k++) begin
      logic e, l;
      e = ($urandom_range(0, 11) != 0);
      l = ($urandom_range(0, 5) == 0);
      apply_stimulus(1'b1, e, l, 16'($urandom), 4'($urandom),
                     4'($urandom) & 4'($urandom) & 4'($urandom));
    end

    run(5, 1'b1);
    load_now(16'h9999, 4'b0000, 4'b0000);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 4'hF);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 4'hF);
    run(36, 1'b1);

    @(posedge clk);
    #2;
    check_output("queue_drained", 8'(exp_q.size()), 8'h00);
    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
